// File: rtl/mic_ext_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mic_ext_responder_pkg                                                      |
// | Shared access codes, size codes and FSM encoding for the external responder|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mic_ext_responder_pkg;

   localparam logic [1:0] ACCESS_READ  = 2'd0;
   localparam logic [1:0] ACCESS_WRITE = 2'd1;
   localparam logic [1:0] ACCESS_CODE  = 2'd2;
   localparam logic [1:0] ACCESS_NONE  = 2'd3;

   localparam logic [3:0] UC_TADDR = 4'h1;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   function automatic logic is_data_access(input logic [1:0] req);
      return (req == ACCESS_READ) || (req == ACCESS_WRITE);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mic_ext_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mic_ext_responder_if                                                       |
// | Downstream valid/ready memory bus between the responder and the fabric     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface mic_ext_responder_if;
   logic        w_ext_valid;
   logic        w_ext_we;
   logic [29:0] w_ext_addr;
   logic [3:0]  w_ext_be;
   logic [31:0] w_ext_wdata;
   logic        w_ext_ready;
   logic [31:0] w_ext_rdata;

   modport master (
      output w_ext_valid, w_ext_we, w_ext_addr, w_ext_be, w_ext_wdata,
      input  w_ext_ready, w_ext_rdata
   );

   modport slave (
      input  w_ext_valid, w_ext_we, w_ext_addr, w_ext_be, w_ext_wdata,
      output w_ext_ready, w_ext_rdata
   );
endinterface
`default_nettype wire

// File: rtl/mic_lane_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mic_lane_align                                                             |
// | Byte-lane steering for stores and extraction/extension for loads           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mic_lane_align
   import mic_ext_responder_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  ctrl,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_lane,
   output logic [31:0] rdata_ext
);

   logic [7:0]  w_rbyte;
   logic [15:0] w_rhalf;

   // ctrl[2] only selects signedness, so stores decode the size from ctrl[1:0]
   always_comb begin
      be         = 4'b1111;
      wdata_lane = wdata;
      case (ctrl[1:0])
         2'b00: begin
            be         = 4'b0001 << addr_lo;
            wdata_lane = {4{wdata[7:0]}};
         end
         2'b01: begin
            be         = 4'b0011 << {addr_lo[1], 1'b0};
            wdata_lane = {2{wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      w_rbyte = rdata[7:0];
      case (addr_lo)
         2'd0:    w_rbyte = rdata[7:0];
         2'd1:    w_rbyte = rdata[15:8];
         2'd2:    w_rbyte = rdata[23:16];
         default: w_rbyte = rdata[31:24];
      endcase
      w_rhalf = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      rdata_ext = rdata;
      case (ctrl)
         F3_B:    rdata_ext = {{24{w_rbyte[7]}}, w_rbyte};
         F3_H:    rdata_ext = {{16{w_rhalf[15]}}, w_rhalf};
         F3_BU:   rdata_ext = {24'd0, w_rbyte};
         F3_HU:   rdata_ext = {16'd0, w_rhalf};
         F3_W:    rdata_ext = rdata;
         default: rdata_ext = rdata;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mic_ext_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mic_ext_responder                                                          |
// | Stalls the CPU and forwards non-local loads/stores to the external bus.    |
// | Optional access timeout: define MIC_RESP_TIMEOUT_EN                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mic_ext_responder
   import mic_ext_responder_pkg::*;
#(
   parameter logic [3:0] LOCAL_TADDR    = UC_TADDR,
   parameter int         TIMEOUT_CYCLES = 255
)(
   input  logic                       CLK,
   input  logic                       RST_X,
   input  logic [31:0]                w_mic_addr,
   input  logic [31:0]                w_mic_wdata,
   input  logic                       w_mic_mmuwe,
   input  logic [2:0]                 w_mic_ctrl,
   input  logic [1:0]                 w_mic_req,
   output logic                       w_stall,
   output logic [31:0]                w_data,
   output logic                       w_timeout,
   mic_ext_responder_if.master        ext
);

   state_t      r_state;
   logic        r_valid;
   logic        r_we;
   logic [29:0] r_eaddr;
   logic [3:0]  r_be;
   logic [31:0] r_wdata;
   logic [31:0] r_data;
   logic [1:0]  r_alo;
   logic [2:0]  r_ctrl;

   logic        w_hit;
   logic        w_idle;
   logic        w_abort;
   logic [1:0]  w_align_alo;
   logic [2:0]  w_align_ctrl;
   logic [3:0]  w_be;
   logic [31:0] w_wlane;
   logic [31:0] w_rext;

   assign w_idle = (r_state == ST_IDLE);
   assign w_hit  = is_data_access(w_mic_req) && (w_mic_addr[31:28] != LOCAL_TADDR);

   // The aligner sees the live CPU request in IDLE and the latched one afterwards
   assign w_align_alo  = w_idle ? w_mic_addr[1:0] : r_alo;
   assign w_align_ctrl = w_idle ? w_mic_ctrl      : r_ctrl;

   mic_lane_align u_align (
      .addr_lo    (w_align_alo),
      .ctrl       (w_align_ctrl),
      .wdata      (w_mic_wdata),
      .rdata      (ext.w_ext_rdata),
      .be         (w_be),
      .wdata_lane (w_wlane),
      .rdata_ext  (w_rext)
   );

`ifdef MIC_RESP_TIMEOUT_EN
   localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

   logic [TO_W-1:0] r_tcnt;
   logic            r_timeout;

   assign w_abort = (r_state == ST_ACCESS) && !ext.w_ext_ready &&
                    (r_tcnt == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         r_tcnt    <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (r_state != ST_ACCESS)
            r_tcnt <= '0;
         else if (!ext.w_ext_ready)
            r_tcnt <= r_tcnt + 1'b1;
         if (w_abort)
            r_timeout <= 1'b1;
      end
   end

   assign w_timeout = r_timeout;
`else
   assign w_abort   = 1'b0;
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         r_state <= ST_IDLE;
         r_valid <= 1'b0;
         r_we    <= 1'b0;
         r_eaddr <= '0;
         r_be    <= '0;
         r_wdata <= '0;
         r_data  <= '0;
         r_alo   <= '0;
         r_ctrl  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_hit) begin
                  r_state <= ST_ACCESS;
                  r_valid <= 1'b1;
                  r_we    <= w_mic_mmuwe;
                  r_eaddr <= w_mic_addr[31:2];
                  r_be    <= w_be;
                  r_wdata <= w_wlane;
                  r_alo   <= w_mic_addr[1:0];
                  r_ctrl  <= w_mic_ctrl;
               end
            end
            ST_ACCESS: begin
               if (ext.w_ext_ready) begin
                  r_valid <= 1'b0;
                  if (!r_we)
                     r_data <= w_rext;
                  r_state <= ST_HOLD;
               end else if (w_abort) begin
                  r_valid <= 1'b0;
                  if (!r_we)
                     r_data <= 32'hFFFF_FFFF;
                  r_state <= ST_HOLD;
               end
            end
            // CPU is still in EX with the same request; do not decode it again
            ST_HOLD: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign w_stall         = (w_idle && w_hit) || (r_state == ST_ACCESS);
   assign w_data          = r_data;
   assign ext.w_ext_valid = r_valid;
   assign ext.w_ext_we    = r_we;
   assign ext.w_ext_addr  = r_eaddr;
   assign ext.w_ext_be    = r_be;
   assign ext.w_ext_wdata = r_wdata;

endmodule
`default_nettype wire
